apb_cmd_master: RTL and testbench
=================================

// Module: apb_cmd_master
// PURPOSE
//  APB initiator: turns single register commands (valid/ready) into APB SETUP/ACCESS transfers.
//  Returns the read data or an error status on a response channel (valid/ready).
//  Sits between an on-chip controller and APB responders such as timer_top.
//  Lets RTL run the same register sequences the verification driver issues.
// PARAMETERS
//  ADDR_W   8    paddr / cmd_addr width
//  DATA_W   8    pwdata / prdata / cmd_wdata / rsp_rdata width
//  TIMEOUT  16   max ACCESS cycles to wait for pready; 0 = wait forever
// PORTS
//  pclk       in   1       single clock, rising edge
//  presetn    in   1       synchronous active-low reset, sampled on pclk
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command accepted when cmd_valid&cmd_ready
//  cmd_write  in   1       1=write, 0=read
//  cmd_addr   in   ADDR_W  target address
//  cmd_wdata  in   DATA_W  write data (ignored for reads)
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       response consumed when rsp_valid&rsp_ready
//  rsp_rdata  out  DATA_W  read data; 0 for writes and errors
//  rsp_err    out  1       1 = transfer timed out
//  psel       out  1       APB select
//  penable    out  1       APB enable
//  pwrite     out  1       APB direction
//  paddr      out  ADDR_W  APB address
//  pwdata     out  DATA_W  APB write data
//  prdata     in   DATA_W  APB read data
//  pready     in   1       APB ready
// BEHAVIOUR
//  Reset (presetn=0 at a pclk edge): every output is 0 and the FSM goes to IDLE.
//   Applies mid-transfer as well: psel/penable drop on the next edge; the command and response are discarded.
//  FSM states: IDLE, SETUP, ACCESS, RESP.
//   IDLE:   cmd_ready=1. On accept, latch pwrite/paddr/pwdata from cmd_*, then go to SETUP.
//   SETUP:  psel=1, penable=0, for exactly one cycle, then go to ACCESS.
//   ACCESS: psel=1, penable=1; the wait counter increments each cycle.
//     pready=1: rsp_rdata<=pwrite?0:prdata, rsp_err<=0, then go to RESP.
//     pready=0 and counter==TIMEOUT-1 (TIMEOUT!=0): rsp_rdata<=0, rsp_err<=1, then go to RESP.
//     If pready arrives in the same cycle as the timeout, pready wins (no error).
//   RESP:   psel=penable=0, rsp_valid=1; rsp_rdata/rsp_err are held stable until rsp_ready.
//     rsp_ready=1: cmd_ready=1 in this same cycle.
//       If cmd_valid, accept the next command and go straight to SETUP.
//       Otherwise go to IDLE.
//  cmd_ready is combinational: (state==IDLE) | (state==RESP & rsp_ready).
//  Latency: accept at edge N -> SETUP N+1 -> ACCESS N+2.
//   With zero-wait pready, rsp_valid is high from N+3.
//   Back-to-back throughput: one transfer per 3 cycles.
//  paddr/pwdata/pwrite are stable from SETUP through the end of ACCESS.
//   They keep their last values in RESP/IDLE and change only on command accept.
//  The wait counter is cleared on entry to SETUP.
//   Its width is $clog2(TIMEOUT+1); it saturates and never wraps.
//  At most one transfer is outstanding; no pipelining or queueing.
//  No pslverr port: the attached responders do not drive it.
// STRUCTURE
//  apb_master_pkg:
//   typedef enum logic [1:0] {IDLE,SETUP,ACCESS,RESP} apb_mst_state_e.
//   Timer register address constants TCR/TSR/TDR/TCNT, shared with the test package.
//  Sub-module apb_wait_timer holds the TIMEOUT counter.
//   Inputs: clr, en. Output: expired.
//  The FSM, address/data registers and response registers stay in apb_cmd_master.
// TESTING
//  1 Write 0x5A to 0x00, pready tied 1:
//    psel rises at N+1, penable at N+2, pwdata=0x5A; rsp_valid at N+3 with rdata=0, err=0.
//  2 Read 0x02 with 3 wait states, prdata=0xC3 on the ready cycle:
//    ACCESS lasts 4 cycles; rsp_rdata=0xC3; paddr is stable throughout.
//  3 pready held 0, TIMEOUT=16:
//    exactly 16 ACCESS cycles, then rsp_err=1, rdata=0, psel=0.
//  4 rsp_ready held 0 for 5 cycles with cmd_valid high:
//    cmd_ready=0 and the response is held stable.
//    On rsp_ready the next command is accepted in the same cycle.
//  5 Back-to-back writes TCR=0x01 then TDR=0xFE against timer_top:
//    the timer registers read back 0x01 and 0xFE; spacing is 3 cycles each.
//  6 presetn=0 during ACCESS:
//    at the next edge all outputs are 0 and the FSM is in IDLE.
//    After release a new read completes normally.

Source files
------------

// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared FSM state type and timer register map for the APB command master.
package apb_master_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_e;
  localparam logic [7:0] TCR  = 8'h00;
  localparam logic [7:0] TSR  = 8'h01;
  localparam logic [7:0] TDR  = 8'h02;
  localparam logic [7:0] TCNT = 8'h03;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating ACCESS-cycle counter that flags the last allowed wait cycle.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);
  logic [CW-1:0] cnt;
  always_ff @(posedge pclk)
    if (!presetn || clr) cnt <= '0;
    else if (en && cnt != MAX) cnt <= cnt + 1'b1;
  // TIMEOUT of 0 means wait forever, so never expire
  assign expired = (TIMEOUT != 0) && en && cnt == LAST;
endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns valid/ready register commands into APB transfers with a timed-out response channel.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);
  apb_mst_state_e state, nxt;
  logic accept, expired, done;
  // gated by presetn so every output reads 0 while reset is held
  assign cmd_ready = presetn & (state == IDLE | (state == RESP & rsp_ready));
  assign accept    = cmd_valid & cmd_ready;
  assign psel      = state == SETUP | state == ACCESS;
  assign penable   = state == ACCESS;
  assign rsp_valid = state == RESP;
  assign done      = state == ACCESS & (pready | expired);
  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .pclk    (pclk),
    .presetn (presetn),
    .clr     (accept),
    .en      (state == ACCESS),
    .expired (expired)
  );
  always_ff @(posedge pclk)
    state <= presetn ? nxt : IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? SETUP : IDLE;
      SETUP:   nxt = ACCESS;
      ACCESS:  nxt = done ? RESP : ACCESS;
      RESP:    nxt = accept ? SETUP : rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end
      // pready takes priority over a timeout landing in the same cycle
      if (done) begin
        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
        rsp_err   <= !pready;
      end
    end
  end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized and directed checks of apb_cmd_master against a register-file reference model.
module tb_apb_cmd_master;
  import apb_master_pkg::*;
  logic pclk = 0, presetn = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [7:0] cmd_addr = 0, cmd_wdata = 0;
  logic rsp_valid, rsp_ready = 0, rsp_err;
  logic [7:0] rsp_rdata;
  logic psel, penable, pwrite, pready = 0;
  logic [7:0] paddr, pwdata, prdata = 0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int wait_cfg = 0, acc_n = 0;
  int n_cmp = 0, n_err = 0;

  apb_cmd_master dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  // APB responder: inserts wait_cfg wait states, then completes the transfer
  always @(negedge pclk) begin
    if (psel && penable) begin
      pready = (acc_n == wait_cfg);
      prdata = pready ? mem[paddr] : 8'($urandom);
      if (pready && pwrite) mem[paddr] = pwdata;
      acc_n++;
    end else begin
      pready = 0;
      acc_n = 0;
      prdata = 8'($urandom);
    end
  end

  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d, input int waits,
                         output logic [7:0] rd, output logic er, output int acc, output int lat,
                         output logic setup_ok, output logic stable);
    wait_cfg = waits;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1; rsp_ready = 1;
    acc = 0; lat = -1; stable = 1; setup_ok = 0; rd = 'x; er = 'x;
    for (int i = 0; i < 50 && !cmd_ready; i++) begin @(posedge pclk); #1; end
    if (!cmd_ready) begin cmd_valid = 0; return; end
    @(posedge pclk); #1;
    cmd_valid = 0;
    setup_ok = psel && !penable && paddr == a && pwrite == w && (!w || pwdata == d);
    for (int i = 2; i < 60; i++) begin
      @(posedge pclk); #1;
      if (rsp_valid) begin
        lat = i; rd = rsp_rdata; er = rsp_err;
        if (psel || penable) stable = 0;
        @(posedge pclk); #1;
        return;
      end
      if (psel && penable) acc++; else stable = 0;
      if (paddr !== a || pwrite !== w || (w && pwdata !== d)) stable = 0;
    end
  endtask

  task automatic test_reset;
    presetn = 0;
    repeat (3) @(posedge pclk);
    #1;
    n_cmp++; if ({psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata} !== '0) begin
      n_err++; $display("FAIL reset_outputs got psel=%b pen=%b crdy=%b rv=%b paddr=%h pwdata=%h rdata=%h, want all 0",
                        psel, penable, cmd_ready, rsp_valid, paddr, pwdata, rsp_rdata); end
    presetn = 1; #1;
    n_cmp++; if (cmd_ready !== 1) begin n_err++; $display("FAIL reset_idle_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_write;
    logic [7:0] rd; logic er, su, st; int acc, lat;
    run_txn(1, TCR, 8'h5A, 0, rd, er, acc, lat, su, st);
    ref_mem[TCR] = 8'h5A;
    n_cmp++; if (su !== 1) begin n_err++; $display("FAIL write_setup got %b want 1", su); end
    n_cmp++; if (lat !== 3 || acc !== 1) begin n_err++; $display("FAIL write_latency got lat=%0d acc=%0d want 3/1", lat, acc); end
    n_cmp++; if ({rd, er} !== 9'h0) begin n_err++; $display("FAIL write_rsp got rdata=%h err=%b want 00/0", rd, er); end
  endtask

  task automatic test_read_wait;
    logic [7:0] rd; logic er, su, st; int acc, lat;
    mem[TDR] = 8'hC3; ref_mem[TDR] = 8'hC3;
    run_txn(0, TDR, 8'h00, 3, rd, er, acc, lat, su, st);
    n_cmp++; if (acc !== 4) begin n_err++; $display("FAIL read_wait_access got %0d want 4", acc); end
    n_cmp++; if (rd !== 8'hC3 || er !== 0) begin n_err++; $display("FAIL read_wait_data got %h/%b want c3/0", rd, er); end
    n_cmp++; if (st !== 1 || su !== 1) begin n_err++; $display("FAIL read_wait_stable got st=%b su=%b want 1/1", st, su); end
  endtask

  task automatic test_timeout;
    logic [7:0] rd; logic er, su, st; int acc, lat;
    run_txn(0, TSR, 8'h00, 1000, rd, er, acc, lat, su, st);
    n_cmp++; if (acc !== 16 || lat !== 18) begin n_err++; $display("FAIL timeout_cycles got acc=%0d lat=%0d want 16/18", acc, lat); end
    n_cmp++; if (rd !== 0 || er !== 1 || st !== 1) begin n_err++; $display("FAIL timeout_rsp got rdata=%h err=%b st=%b want 00/1/1", rd, er, st); end
    run_txn(0, TDR, 8'h00, 15, rd, er, acc, lat, su, st);
    n_cmp++; if (acc !== 16 || er !== 0 || rd !== ref_mem[TDR]) begin
      n_err++; $display("FAIL timeout_edge_pready got acc=%0d err=%b rdata=%h want 16/0/%h", acc, er, rd, ref_mem[TDR]); end
  endtask

  task automatic test_backpressure;
    logic [7:0] held; int bad;
    wait_cfg = 0; rsp_ready = 0; cmd_write = 0; cmd_addr = TCR; cmd_valid = 1;
    @(posedge pclk); #1;
    cmd_valid = 0;
    for (int i = 0; i < 10 && !rsp_valid; i++) begin @(posedge pclk); #1; end
    n_cmp++; if (rsp_valid !== 1 || rsp_rdata !== ref_mem[TCR]) begin
      n_err++; $display("FAIL bp_first_rsp got rv=%b rdata=%h want 1/%h", rsp_valid, rsp_rdata, ref_mem[TCR]); end
    held = rsp_rdata; bad = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = TDR; cmd_wdata = 8'hFE;
    for (int i = 0; i < 5; i++) begin
      if (cmd_ready !== 0 || rsp_valid !== 1 || rsp_rdata !== held || rsp_err !== 0 || psel !== 0) bad++;
      @(posedge pclk); #1;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    rsp_ready = 1; #1;
    n_cmp++; if (cmd_ready !== 1) begin n_err++; $display("FAIL bp_same_cycle_ready got %b want 1", cmd_ready); end
    @(posedge pclk); #1;
    cmd_valid = 0; ref_mem[TDR] = 8'hFE;
    n_cmp++; if ({psel, penable, paddr, pwdata} !== {1'b1, 1'b0, TDR, 8'hFE}) begin
      n_err++; $display("FAIL bp_next_setup got psel=%b pen=%b paddr=%h pwdata=%h want 1/0/%h/fe", psel, penable, paddr, pwdata, TDR); end
    for (int i = 0; i < 10 && !rsp_valid; i++) begin @(posedge pclk); #1; end
    n_cmp++; if (rsp_valid !== 1 || rsp_err !== 0 || rsp_rdata !== 0) begin
      n_err++; $display("FAIL bp_second_rsp got rv=%b err=%b rdata=%h want 1/0/00", rsp_valid, rsp_err, rsp_rdata); end
    @(posedge pclk); #1;
  endtask

  task automatic test_back_to_back;
    logic cw [4];
    logic [7:0] ca [4], cd [4], ex [4];
    int idx, cyc, last, nrsp, sp_bad, d_bad;
    logic acc_now;
    cw = '{1, 1, 0, 0}; ca = '{TCR, TDR, TCR, TDR}; cd = '{8'h01, 8'hFE, 8'h00, 8'h00};
    ex = '{8'h00, 8'h00, 8'h01, 8'hFE};
    idx = 0; cyc = 0; last = -1; nrsp = 0; sp_bad = 0; d_bad = 0;
    wait_cfg = 0; rsp_ready = 1;
    cmd_write = cw[0]; cmd_addr = ca[0]; cmd_wdata = cd[0]; cmd_valid = 1;
    while (nrsp < 4 && cyc < 60) begin
      acc_now = cmd_valid && cmd_ready;
      if (rsp_valid) begin
        if (rsp_rdata !== ex[nrsp] || rsp_err !== 0) d_bad++;
        nrsp++;
      end
      @(posedge pclk); #1;
      cyc++;
      if (acc_now) begin
        if (last >= 0 && cyc - last != 3) sp_bad++;
        last = cyc; idx++;
        if (idx < 4) begin cmd_write = cw[idx]; cmd_addr = ca[idx]; cmd_wdata = cd[idx]; end
        else cmd_valid = 0;
      end
    end
    cmd_valid = 0;
    ref_mem[TCR] = 8'h01; ref_mem[TDR] = 8'hFE;
    n_cmp++; if (nrsp !== 4) begin n_err++; $display("FAIL b2b_count got %0d responses want 4", nrsp); end
    n_cmp++; if (sp_bad !== 0) begin n_err++; $display("FAIL b2b_spacing got %0d bad gaps want 0", sp_bad); end
    n_cmp++; if (d_bad !== 0) begin n_err++; $display("FAIL b2b_readback got %0d bad responses want 0", d_bad); end
    @(posedge pclk); #1;
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd; logic er, su, st; int acc, lat;
    wait_cfg = 1000; rsp_ready = 1; cmd_write = 0; cmd_addr = TCNT; cmd_valid = 1;
    for (int i = 0; i < 10 && !cmd_ready; i++) begin @(posedge pclk); #1; end
    @(posedge pclk); #1;
    cmd_valid = 0;
    repeat (3) @(posedge pclk);
    #1;
    n_cmp++; if (psel !== 1 || penable !== 1) begin n_err++; $display("FAIL rstmid_in_access got psel=%b pen=%b want 1/1", psel, penable); end
    presetn = 0;
    @(posedge pclk); #1;
    n_cmp++; if ({psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata} !== '0) begin
      n_err++; $display("FAIL rstmid_outputs got psel=%b pen=%b crdy=%b rv=%b paddr=%h want all 0", psel, penable, cmd_ready, rsp_valid, paddr); end
    presetn = 1; #1;
    n_cmp++; if (cmd_ready !== 1 || rsp_valid !== 0) begin n_err++; $display("FAIL rstmid_idle got crdy=%b rv=%b want 1/0", cmd_ready, rsp_valid); end
    run_txn(0, TDR, 8'h00, 2, rd, er, acc, lat, su, st);
    n_cmp++; if (rd !== ref_mem[TDR] || er !== 0 || acc !== 3 || lat !== 5) begin
      n_err++; $display("FAIL rstmid_after_read got rdata=%h err=%b acc=%0d lat=%0d want %h/0/3/5", rd, er, acc, lat, ref_mem[TDR]); end
  endtask

  task automatic test_random;
    logic [7:0] rd, a, d, exp_rd; logic er, su, st, w, exp_err; int acc, lat, waits, exp_acc;
    for (int n = 0; n < 24; n++) begin
      w = 1'($urandom); a = 8'($urandom); d = 8'($urandom);
      waits = ($urandom_range(0, 7) == 0) ? 14 + int'($urandom_range(0, 4)) : int'($urandom_range(0, 4));
      exp_err = waits >= 16;
      exp_acc = exp_err ? 16 : waits + 1;
      exp_rd  = (w || exp_err) ? 8'h00 : ref_mem[a];
      if (w && !exp_err) ref_mem[a] = d;
      run_txn(w, a, d, waits, rd, er, acc, lat, su, st);
      n_cmp++; if ({rd, er} !== {exp_rd, exp_err} || acc !== exp_acc || lat !== exp_acc + 2 || su !== 1 || st !== 1) begin
        n_err++; $display("FAIL rand_txn%0d w=%b a=%h waits=%0d got rdata=%h err=%b acc=%0d lat=%0d su=%b st=%b want %h/%b/%0d/%0d/1/1",
                          n, w, a, waits, rd, er, acc, lat, su, st, exp_rd, exp_err, exp_acc, exp_acc + 2); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    test_reset;
    test_write;
    test_read_wait;
    test_timeout;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
